// File: rtl/pwm_breathe_multi_pkg.sv
// ---------------------------------------------------------------------------
// pwm_breathe_multi_pkg
//   Shared types and helpers for the multi-channel PWM/breathe generator.
//   - breathe_state_e : per-channel breathing ramp direction (UP, DOWN)
//   - period(dw)      : PWM period in counter ticks, 2**dw - 1
// ---------------------------------------------------------------------------
package pwm_breathe_multi_pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } breathe_state_e;

    function automatic int period(input int dw);
        return (1 << dw) - 1;
    endfunction

endpackage

// File: rtl/pwm_breathe_multi_if.sv
// ---------------------------------------------------------------------------
// pwm_breathe_multi_if
//   Control/data bundle between a PWM controller (master) and the
//   pwm_breathe_multi block (slave).
//   en           : global enable
//   duty_in      : CH packed duty values, channel i at [i*DW +: DW]
//   duty_we      : per-channel duty write strobe
//   breathe_en   : per-channel breathing mode select
//   pwm_out      : registered PWM outputs
//   period_start : one-cycle pulse aligned with pwm_out showing cnt = 0
// ---------------------------------------------------------------------------
interface pwm_breathe_multi_if #(
    parameter int CH = 4,
    parameter int DW = 6
);
    logic             en;
    logic [CH*DW-1:0] duty_in;
    logic [CH-1:0]    duty_we;
    logic [CH-1:0]    breathe_en;
    logic [CH-1:0]    pwm_out;
    logic             period_start;

    modport master (
        output en, duty_in, duty_we, breathe_en,
        input  pwm_out, period_start
    );

    modport slave (
        input  en, duty_in, duty_we, breathe_en,
        output pwm_out, period_start
    );
endinterface

// File: rtl/pwm_breathe_multi_chan.sv
// ---------------------------------------------------------------------------
// pwm_breathe_multi_chan
//   One PWM channel: shadow/active duty double buffer, breathing ramp FSM,
//   current level and registered compare output.
//   Optional feature macro: PWM_PHASE_STAGGER_EN (phase offset IDX*(P/CH)).
//   clk, rst  : clock, asynchronous active-high reset
//   en        : global enable (output forced low when 0)
//   wrap      : period boundary strobe from the shared counter
//   step_tick : breathe step strobe (subset of wrap)
//   cnt       : shared period counter
//   duty, we  : duty value and write strobe
//   breathe   : breathing mode select
//   pwm       : registered PWM output
// ---------------------------------------------------------------------------
module pwm_breathe_multi_chan
    import pwm_breathe_multi_pkg::*;
#(
    parameter int DW  = 6,
    parameter int CH  = 4,
    parameter int IDX = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          wrap,
    input  logic          step_tick,
    input  logic [DW-1:0] cnt,
    input  logic [DW-1:0] duty,
    input  logic          we,
    input  logic          breathe,
    output logic          pwm
);
    localparam int P = period(DW);
`ifdef PWM_PHASE_STAGGER_EN
    localparam int OFF = IDX * (P / CH);
`else
    localparam int OFF = 0 * IDX * CH;
`endif

    logic [DW-1:0]  shadow;
    logic [DW-1:0]  active;
    logic [DW-1:0]  level;
    logic [DW-1:0]  tgt;
    logic [DW-1:0]  cmp;
    logic [DW:0]    sum;
    logic           brth_q;
    breathe_state_e state;

    // A write landing in the wrap cycle goes straight to active.
    assign tgt = we ? duty : shadow;

    // (cnt + OFF) mod P; OFF < P so one conditional subtract suffices.
    always_comb begin
        sum = {1'b0, cnt} + (DW+1)'(OFF);
        cmp = sum[DW-1:0];
        if (sum >= (DW+1)'(P)) begin
            cmp = DW'(sum - (DW+1)'(P));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            level  <= '0;
            brth_q <= 1'b0;
            state  <= UP;
            pwm    <= 1'b0;
        end else begin
            if (we) begin
                shadow <= duty;
            end
            if (wrap) begin
                active <= tgt;
                brth_q <= breathe;
                if (!breathe) begin
                    level <= tgt;
                    state <= UP;
                end else if (!brth_q) begin
                    // breathing just switched on: restart the ramp from zero
                    level <= '0;
                    state <= UP;
                end else if (tgt == '0) begin
                    level <= '0;
                    state <= UP;
                end else if (level > tgt) begin
                    // target dropped below the ramp: clamp and head down
                    level <= tgt;
                    state <= DOWN;
                end else if (step_tick) begin
                    case (state)
                        UP: begin
                            if (level < tgt) begin
                                level <= level + DW'(1);
                                if (level == tgt - DW'(1)) state <= DOWN;
                            end else begin
                                state <= DOWN;
                            end
                        end
                        DOWN: begin
                            if (level != '0) begin
                                level <= level - DW'(1);
                                if (level == DW'(1)) state <= UP;
                            end else begin
                                state <= UP;
                            end
                        end
                        default: state <= UP;
                    endcase
                end
            end
            pwm <= en && (cmp < level);
        end
    end
endmodule

// File: rtl/pwm_breathe_multi.sv
// ---------------------------------------------------------------------------
// pwm_breathe_multi
//   Multi-channel PWM generator with per-channel breathing envelope.
//   Shared prescaler, period counter (0..P-1, P = 2**DW-1) and breathe step
//   counter feed CH pwm_breathe_multi_chan instances.
//   Optional feature macro: PWM_PHASE_STAGGER_EN (staggered channel phases).
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : pwm_breathe_multi_if.slave (en, duty_in, duty_we, breathe_en,
//          pwm_out, period_start)
// ---------------------------------------------------------------------------
module pwm_breathe_multi
    import pwm_breathe_multi_pkg::*;
#(
    parameter int CH       = 4,
    parameter int DW       = 6,
    parameter int PRESCALE = 1,
    parameter int STEP_PER = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_breathe_multi_if.slave   bus
);
    localparam int P  = period(DW);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (STEP_PER > 1) ? $clog2(STEP_PER) : 1;

    logic [PW-1:0] presc;
    logic [DW-1:0] cnt;
    logic [SW-1:0] step;
    logic          tick;
    logic          wrap;
    logic          step_tick;
    logic          wrap_d;
    logic          start;
    logic [CH-1:0] pwm;

    assign tick      = bus.en && (presc == PW'(PRESCALE - 1));
    assign wrap      = tick && (cnt == DW'(P - 1));
    assign step_tick = wrap && (step == SW'(STEP_PER - 1));

    // period_start is delayed twice from wrap so it lines up with the
    // registered pwm_out that reflects cnt = 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc  <= '0;
            cnt    <= '0;
            step   <= '0;
            wrap_d <= 1'b0;
            start  <= 1'b0;
        end else if (!bus.en) begin
            presc  <= '0;
            cnt    <= '0;
            step   <= '0;
            wrap_d <= 1'b0;
            start  <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                cnt <= wrap ? '0 : cnt + DW'(1);
            end
            if (wrap) begin
                step <= step_tick ? '0 : step + SW'(1);
            end
            wrap_d <= wrap;
            start  <= wrap_d;
        end
    end

    assign bus.period_start = start;
    assign bus.pwm_out      = pwm;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pwm_breathe_multi_chan #(
            .DW  (DW),
            .CH  (CH),
            .IDX (i)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en        (bus.en),
            .wrap      (wrap),
            .step_tick (step_tick),
            .cnt       (cnt),
            .duty      (bus.duty_in[i*DW +: DW]),
            .we        (bus.duty_we[i]),
            .breathe   (bus.breathe_en[i]),
            .pwm       (pwm[i])
        );
    end
endmodule

// File: tb/tb_pwm_breathe_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_breathe_multi
//   Directed bench: instance A (PRESCALE=1, STEP_PER=1) and instance B
//   (PRESCALE=3, STEP_PER=2), CH=4, DW=6. High-time per period is counted
//   over windows aligned to period_start.
// ---------------------------------------------------------------------------
module tb_pwm_breathe_multi;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pwm_breathe_multi_if #(.CH(4), .DW(6)) ifa ();
    pwm_breathe_multi_if #(.CH(4), .DW(6)) ifb ();

    pwm_breathe_multi #(.CH(4), .DW(6), .PRESCALE(1), .STEP_PER(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    pwm_breathe_multi #(.CH(4), .DW(6), .PRESCALE(3), .STEP_PER(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Wait for period_start, then count high samples per channel for len
    // clocks; optionally drive a write at sample wr_at. Ends on the negedge
    // following the window (the next period_start when the period is len).
    task automatic measure(input bit sel, input int len, input int wr_at,
                           input logic [23:0] d, input logic [3:0] we,
                           input logic [3:0] br, output int hi [4],
                           output int waited);
        logic [3:0] p;
        logic       ps;
        waited = 0;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        ps = sel ? ifb.period_start : ifa.period_start;
        while (!ps && waited < 400) begin
            @(negedge clk);
            waited++;
            ps = sel ? ifb.period_start : ifa.period_start;
        end
        checks++;
        if (ps !== 1'b1) begin
            errors++;
            $display("FAIL period_start_timeout: saw %b after %0d clk, need 1", ps, waited);
            return;
        end
        for (int k = 0; k < len; k++) begin
            if (k == wr_at) begin
                if (sel) begin
                    ifb.duty_in = d; ifb.duty_we = we; ifb.breathe_en = br;
                end else begin
                    ifa.duty_in = d; ifa.duty_we = we; ifa.breathe_en = br;
                end
            end
            if (k == wr_at + 1) begin
                if (sel) ifb.duty_we = 4'b0000;
                else     ifa.duty_we = 4'b0000;
            end
            p = sel ? ifb.pwm_out : ifa.pwm_out;
            for (int c = 0; c < 4; c++) hi[c] += int'(p[c]);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ifa.en = 1'b0; ifa.duty_in = '0; ifa.duty_we = '0; ifa.breathe_en = '0;
        ifb.en = 1'b0; ifb.duty_in = '0; ifb.duty_we = '0; ifb.breathe_en = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (ifa.pwm_out !== 4'b0000) begin
            errors++; $display("FAIL reset_pwm_a: got %b want 0000", ifa.pwm_out);
        end
        checks++;
        if (ifa.period_start !== 1'b0) begin
            errors++; $display("FAIL reset_ps_a: got %b want 0", ifa.period_start);
        end
        checks++;
        if (ifb.pwm_out !== 4'b0000) begin
            errors++; $display("FAIL reset_pwm_b: got %b want 0000", ifb.pwm_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle;
        int nz;
        int first;
        int second;
        nz = 0; first = -1; second = -1;
        ifa.en = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (ifa.pwm_out !== 4'b0000) nz++;
            if (ifa.period_start === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        checks++;
        if (nz !== 0) begin
            errors++; $display("FAIL idle_pwm_zero: %0d nonzero samples, want 0", nz);
        end
        checks++;
        if (first !== 64) begin
            errors++; $display("FAIL idle_first_ps: at clk %0d, want 64", first);
        end
        checks++;
        if (second - first !== 63) begin
            errors++; $display("FAIL idle_ps_period: %0d clk, want 63", second - first);
        end
    endtask

    task automatic test_duty;
        int hi [4];
        int w;
        int exp2 [4];
        int exp3 [4];
        exp2 = '{6, 63, 0, 32};
        exp3 = '{10, 63, 0, 32};
        measure(1'b0, 63, 20, {6'd32, 6'd0, 6'd63, 6'd6}, 4'b1111, 4'b0000, hi, w);
        checks++;
        if (hi[0] + hi[1] + hi[2] + hi[3] !== 0) begin
            errors++; $display("FAIL duty_write_period: high sum %0d, want 0", hi[0] + hi[1] + hi[2] + hi[3]);
        end
        measure(1'b0, 63, 30, {6'd32, 6'd0, 6'd63, 6'd10}, 4'b0001, 4'b0000, hi, w);
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL duty_period_len: waited %0d, want 0", w);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (hi[c] !== exp2[c]) begin
                errors++; $display("FAIL duty_ch%0d: high %0d, want %0d", c, hi[c], exp2[c]);
            end
        end
        measure(1'b0, 63, -1, '0, 4'b0000, 4'b0000, hi, w);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (hi[c] !== exp3[c]) begin
                errors++; $display("FAIL duty_update_ch%0d: high %0d, want %0d", c, hi[c], exp3[c]);
            end
        end
    endtask

    task automatic test_breathe;
        int hi [4];
        int w;
        int exp_seq [10];
        exp_seq = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
        measure(1'b0, 63, 10, {6'd32, 6'd0, 6'd63, 6'd4}, 4'b0001, 4'b0001, hi, w);
        checks++;
        if (hi[0] !== 10) begin
            errors++; $display("FAIL breathe_enable_period: high %0d, want 10", hi[0]);
        end
        for (int n = 0; n < 10; n++) begin
            measure(1'b0, 63, -1, '0, 4'b0000, 4'b0001, hi, w);
            checks++;
            if (hi[0] !== exp_seq[n]) begin
                errors++; $display("FAIL breathe_step%0d: high %0d, want %0d", n, hi[0], exp_seq[n]);
            end
        end
        checks++;
        if (hi[3] !== 32) begin
            errors++; $display("FAIL breathe_other_ch: ch3 high %0d, want 32", hi[3]);
        end
    endtask

    task automatic test_clamp;
        int hi [4];
        int w;
        int tail [3];
        tail = '{5, 4, 3};
        measure(1'b0, 63, 5, {6'd32, 6'd0, 6'd63, 6'd20}, 4'b0001, 4'b0001, hi, w);
        checks++;
        if (hi[0] !== 2) begin
            errors++; $display("FAIL clamp_pre: high %0d, want 2", hi[0]);
        end
        for (int lv = 3; lv <= 10; lv++) begin
            if (lv == 10)
                measure(1'b0, 63, 5, {6'd32, 6'd0, 6'd63, 6'd5}, 4'b0001, 4'b0001, hi, w);
            else
                measure(1'b0, 63, -1, '0, 4'b0000, 4'b0001, hi, w);
            checks++;
            if (hi[0] !== lv) begin
                errors++; $display("FAIL clamp_ramp: high %0d, want %0d", hi[0], lv);
            end
        end
        for (int n = 0; n < 3; n++) begin
            measure(1'b0, 63, -1, '0, 4'b0000, 4'b0001, hi, w);
            checks++;
            if (hi[0] !== tail[n]) begin
                errors++; $display("FAIL clamp_down%0d: high %0d, want %0d", n, hi[0], tail[n]);
            end
        end
    endtask

    task automatic test_enable;
        int bad;
        int n;
        bad = 0;
        repeat (20) @(negedge clk);
        ifa.en = 1'b0;
        @(negedge clk);
        checks++;
        if (ifa.pwm_out !== 4'b0000) begin
            errors++; $display("FAIL en_off_pwm: got %b want 0000", ifa.pwm_out);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifa.pwm_out !== 4'b0000 || ifa.period_start !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL en_off_hold: %0d active samples, want 0", bad);
        end
        ifa.en = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (ifa.period_start === 1'b1) break;
        end
        checks++;
        if (n !== 64) begin
            errors++; $display("FAIL en_restart_ps: at clk %0d, want 64", n);
        end
    endtask

    task automatic test_async_reset;
        repeat (5) @(negedge clk);
        checks++;
        if (ifa.pwm_out[1] !== 1'b1) begin
            errors++; $display("FAIL areset_pre: ch1 %b, want 1", ifa.pwm_out[1]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ifa.pwm_out !== 4'b0000) begin
            errors++; $display("FAIL areset_immediate: got %b want 0000", ifa.pwm_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (ifa.pwm_out !== 4'b0000) begin
            errors++; $display("FAIL areset_duty_cleared: got %b want 0000", ifa.pwm_out);
        end
    endtask

    task automatic test_prescale_step;
        int hi [4];
        int w;
        int exp_seq [10];
        exp_seq = '{0, 3, 3, 6, 6, 3, 3, 0, 0, 3};
        ifb.en = 1'b1;
        ifb.duty_in = {6'd0, 6'd0, 6'd0, 6'd2};
        ifb.duty_we = 4'b0001;
        ifb.breathe_en = 4'b0001;
        @(negedge clk);
        ifb.duty_we = 4'b0000;
        for (int n = 0; n < 10; n++) begin
            measure(1'b1, 189, -1, '0, 4'b0000, 4'b0001, hi, w);
            if (n == 1) begin
                checks++;
                if (w !== 0) begin
                    errors++; $display("FAIL prescale_period: waited %0d, want 0 (period 189)", w);
                end
            end
            checks++;
            if (hi[0] !== exp_seq[n]) begin
                errors++; $display("FAIL step_per2_p%0d: high %0d, want %0d", n + 1, hi[0], exp_seq[n]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_idle();
        test_duty();
        test_breathe();
        test_clamp();
        test_enable();
        test_async_reset();
        test_prescale_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
